// File: rtl/sa_output_collector.sv
// sa_output_collector
//   Drains N_ARR systolic arrays into a row-major, de-skewed beat stream.
//   Each array column delivers its results one row at a time with arbitrary
//   skew; words are parked in a per-column buffer that holds a full tile, and
//   a row is released only once every column of it has arrived.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, tile_rows,        tile start (IDLE only); row count and enabled
//   arr_mask                 arrays are sampled on an accepted start
//   sa_output, sa_valid_out  per-array, per-column result words and valids
//   out_data/out_arr/out_row one de-skewed row, its source array and index
//   out_valid, out_ready     beat handshake
//   busy, done               RUN or DONE / DONE only
//   err_overflow, err_stray  sticky: word past row count / unexpected word

// Per-column capture lane: write counter, row storage and error detection.
module sa_oc_col #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int RW    = 5,
    parameter int IW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          run,
    input  logic          en,
    input  logic [RW-1:0] rows,
    input  logic          valid,
    input  logic [DW-1:0] din,
    input  logic [RW-1:0] rd_row,
    output logic [DW-1:0] rd_data,
    output logic          row_ok,
    output logic          ovf,
    output logic          stray
);
    logic [RW-1:0] wcnt;
    logic [DW-1:0] mem [DEPTH];
    logic          take;
    logic          wr;

    assign take  = valid && run && en;
    assign wr    = take && (wcnt < rows);
    assign ovf   = take && (wcnt >= rows);
    assign stray = valid && !(run && en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wcnt <= '0;
        else if (clr)
            wcnt <= '0;
        else if (wr)
            wcnt <= wcnt + RW'(1);
    end

    // Storage is never visible while out_valid is low, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr)
            mem[wcnt[IW-1:0]] <= din;
    end

    assign rd_data = mem[rd_row[IW-1:0]];
    assign row_ok  = wcnt > rd_row;
endmodule

module sa_output_collector #(
    parameter int N_ARR = 4,
    parameter int N_COL = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    localparam int RW   = $clog2(DEPTH + 1),
    localparam int AW   = (N_ARR > 1) ? $clog2(N_ARR) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [RW-1:0]                       tile_rows,
    input  logic [N_ARR-1:0]                    arr_mask,
    input  logic [N_ARR-1:0][N_COL-1:0][DW-1:0] sa_output,
    input  logic [N_ARR-1:0][N_COL-1:0]         sa_valid_out,
    output logic [N_COL-1:0][DW-1:0]            out_data,
    output logic [AW-1:0]                       out_arr,
    output logic [RW-1:0]                       out_row,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                done,
    output logic                                err_overflow,
    output logic                                err_stray
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                              state;
    logic [RW-1:0]                       rows_q;
    logic [N_ARR-1:0]                    mask_q;
    logic [RW-1:0]                       head_row;
    logic [AW-1:0]                       head_arr;

    logic [N_ARR-1:0][N_COL-1:0]         row_ok;
    logic [N_ARR-1:0][N_COL-1:0]         ovf_hit;
    logic [N_ARR-1:0][N_COL-1:0]         stray_hit;
    logic [N_ARR-1:0][N_COL-1:0][DW-1:0] rd_data;

    logic          run;
    logic          start_ok;
    logic          head_done;
    logic          fire;
    logic          last;
    logic          nxt_found;
    logic [AW-1:0] nxt_arr;

    function automatic logic [AW-1:0] lowest(input logic [N_ARR-1:0] m);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = N_ARR - 1; i >= 0; i--)
            if (m[i]) idx = AW'(i);
        return idx;
    endfunction

    assign run      = (state == RUN);
    assign start_ok = (state == IDLE) && start && (|arr_mask) && (tile_rows != '0);

    for (genvar a = 0; a < N_ARR; a++) begin : g_arr
        for (genvar c = 0; c < N_COL; c++) begin : g_col
            sa_oc_col #(.DW(DW), .DEPTH(DEPTH), .RW(RW), .IW(IW)) u_col (
                .clk     (clk),
                .rst     (rst),
                .clr     (start_ok),
                .run     (run),
                .en      (mask_q[a]),
                .rows    (rows_q),
                .valid   (sa_valid_out[a][c]),
                .din     (sa_output[a][c]),
                .rd_row  (head_row),
                .rd_data (rd_data[a][c]),
                .row_ok  (row_ok[a][c]),
                .ovf     (ovf_hit[a][c]),
                .stray   (stray_hit[a][c])
            );
        end
    end

    // Next enabled array above the head in the current row, if any.
    always_comb begin
        nxt_found = 1'b0;
        nxt_arr   = '0;
        for (int i = N_ARR - 1; i >= 0; i--) begin
            if (mask_q[i] && (AW'(i) > head_arr)) begin
                nxt_found = 1'b1;
                nxt_arr   = AW'(i);
            end
        end
    end

    assign head_done = &row_ok[head_arr];
    assign out_valid = run && head_done;
    assign fire      = out_valid && out_ready;
    assign last      = (head_row == rows_q - RW'(1)) && !nxt_found;

    assign out_data  = out_valid ? rd_data[head_arr] : '0;
    assign out_arr   = out_valid ? head_arr : '0;
    assign out_row   = out_valid ? head_row : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rows_q       <= '0;
            mask_q       <= '0;
            head_row     <= '0;
            head_arr     <= '0;
            err_overflow <= 1'b0;
            err_stray    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state    <= RUN;
                        rows_q   <= tile_rows;
                        mask_q   <= arr_mask;
                        head_row <= '0;
                        head_arr <= lowest(arr_mask);
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (last) begin
                            state <= DONE;
                        end else if (nxt_found) begin
                            head_arr <= nxt_arr;
                        end else begin
                            head_arr <= lowest(mask_q);
                            head_row <= head_row + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A fresh error in the start cycle survives the clear.
            if (start_ok) begin
                err_overflow <= |ovf_hit;
                err_stray    <= |stray_hit;
            end else begin
                err_overflow <= err_overflow | (|ovf_hit);
                err_stray    <= err_stray | (|stray_hit);
            end
        end
    end
endmodule

// File: tb/tb_sa_output_collector.sv
module tb_sa_output_collector;
    localparam int N_ARR = 4;
    localparam int N_COL = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int RW    = 5;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic rst, start, out_ready, out_valid, busy, done, err_overflow, err_stray;
    logic [RW-1:0] tile_rows, out_row;
    logic [N_ARR-1:0] arr_mask;
    logic [AW-1:0] out_arr;
    logic [N_ARR-1:0][N_COL-1:0][DW-1:0] sa_output;
    logic [N_ARR-1:0][N_COL-1:0] sa_valid_out;
    logic [N_COL-1:0][DW-1:0] out_data;

    sa_output_collector #(.N_ARR(N_ARR), .N_COL(N_COL), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .tile_rows(tile_rows), .arr_mask(arr_mask),
        .sa_output(sa_output), .sa_valid_out(sa_valid_out), .out_data(out_data),
        .out_arr(out_arr), .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err_overflow(err_overflow), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int start_cyc = 0;
    int first_v = -1;
    int done_lat = -1;
    int nbeats = 0;
    int beat_arr[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic chkd(input string nm, input logic [N_COL*DW-1:0] act, input logic [N_COL*DW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] word(input int a, input int r, input int c);
        return DW'((a << 12) | (r << 8) | c);
    endfunction

    // ---------------- behavioural model ----------------
    // Tile = list of (array,row) beats in spec order; a beat is offered once
    // the model has counted every column of that row for that array.
    int m_state = 0;              // 0 idle, 1 run, 2 done
    int m_rows = 0;
    logic [N_ARR-1:0] m_mask = '0;
    int m_cnt[N_ARR][N_COL];
    int q_arr[$];
    int q_row[$];
    bit m_ovf = 0;
    bit m_stray = 0;

    function automatic bit m_head_ok();
        if (m_state != 1 || q_arr.size() == 0) return 0;
        for (int c = 0; c < N_COL; c++)
            if (m_cnt[q_arr[0]][c] <= q_row[0]) return 0;
        return 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int old;
        bit acc;
        if (rst) begin
            m_state = 0;
            q_arr.delete();
            q_row.delete();
            m_ovf = 0;
            m_stray = 0;
            for (int a = 0; a < N_ARR; a++)
                for (int c = 0; c < N_COL; c++) m_cnt[a][c] = 0;
        end else begin
            old = m_state;
            acc = m_head_ok() && out_ready;
            if (acc) begin
                void'(q_arr.pop_front());
                void'(q_row.pop_front());
            end
            case (old)
                0: if (start && arr_mask != 0 && tile_rows != 0) begin
                    m_state = 1;
                    m_rows = int'(tile_rows);
                    m_mask = arr_mask;
                    m_ovf = 0;
                    m_stray = 0;
                    for (int a = 0; a < N_ARR; a++)
                        for (int c = 0; c < N_COL; c++) m_cnt[a][c] = 0;
                    for (int r = 0; r < m_rows; r++)
                        for (int a = 0; a < N_ARR; a++)
                            if (m_mask[a]) begin q_arr.push_back(a); q_row.push_back(r); end
                end
                1: if (acc && q_arr.size() == 0) m_state = 2;
                default: m_state = 0;
            endcase
            for (int a = 0; a < N_ARR; a++)
                for (int c = 0; c < N_COL; c++)
                    if (sa_valid_out[a][c]) begin
                        if (old == 1 && m_mask[a]) begin
                            if (m_cnt[a][c] < m_rows) m_cnt[a][c]++;
                            else m_ovf = 1;
                        end else m_stray = 1;
                    end
        end
    end

    // ---------------- compare process ----------------
    logic [N_COL-1:0][DW-1:0] exp_d, prev_d;
    bit hold = 0;

    always @(negedge clk) begin
        bit ev;
        ev = m_head_ok();
        chk("out_valid", out_valid, ev);
        chk("busy", busy, m_state != 0);
        chk("done", done, m_state == 2);
        chk("err_overflow", err_overflow, m_ovf);
        chk("err_stray", err_stray, m_stray);
        if (ev) begin
            chk("out_arr", out_arr, q_arr[0]);
            chk("out_row", out_row, q_row[0]);
            for (int c = 0; c < N_COL; c++) exp_d[c] = word(q_arr[0], q_row[0], c);
            chkd("out_data", out_data, exp_d);
        end
        if (hold && out_valid) chkd("hold_stable", out_data, prev_d);
        hold = out_valid && !out_ready;
        prev_d = out_data;
        if (out_valid && out_ready) begin
            nbeats++;
            beat_arr.push_back(int'(out_arr));
        end
        if (out_valid && first_v < 0) first_v = cyc - start_cyc;
        if (done && done_lat < 0) done_lat = cyc - start_cyc;
    end

    // ---------------- stimulus ----------------
    task automatic start_tile(input int r, input logic [N_ARR-1:0] m);
        tile_rows = RW'(r);
        arr_mask = m;
        start = 1'b1;
        nbeats = 0;
        beat_arr.delete();
        first_v = -1;
        done_lat = -1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Column c of row r is driven at cycle k = r + skew*c.
    task automatic feed(input int rows, input logic [N_ARR-1:0] fm, input int skew,
                        input int maxk, input int st_from, input int st_len);
        int kmax;
        int r;
        kmax = rows + skew * (N_COL - 1);
        for (int k = 0; k < kmax && k < maxk; k++) begin
            for (int a = 0; a < N_ARR; a++)
                for (int c = 0; c < N_COL; c++) begin
                    r = k - skew * c;
                    sa_valid_out[a][c] = fm[a] && r >= 0 && r < rows;
                    sa_output[a][c] = sa_valid_out[a][c] ? word(a, r, c) : '0;
                end
            if (st_len > 0) out_ready = !(k >= st_from && k < st_from + st_len);
            @(posedge clk); #1;
        end
        sa_valid_out = '0;
        sa_output = '0;
        if (st_len > 0) out_ready = 1'b1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", done, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"}, err_overflow, 0);
        chk({tag, "_stray"}, err_stray, 0);
        chk({tag, "_arr"}, out_arr, 0);
        chk({tag, "_row"}, out_row, 0);
        chkd({tag, "_data"}, out_data, '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tile_rows = '0; arr_mask = '0;
        sa_output = '0; sa_valid_out = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // rows=2, one array, column skew of c cycles
        start_tile(2, 4'b0001);
        feed(2, 4'b0001, 1, 999, 0, 0);
        wait_done();
        chk("t1_first_valid_lat", first_v, 16);
        chk("t1_done_lat", done_lat, 18);
        chk("t1_beats", nbeats, 2);

        // any valid in IDLE is stray
        sa_valid_out[2][3] = 1'b1;
        @(posedge clk); #1;
        sa_valid_out = '0;
        chk("idle_stray", err_stray, 1);

        // rows=1, mask 1010, all arrays driving: arrays 0/2 are stray
        start_tile(1, 4'b1010);
        feed(1, 4'b1111, 0, 999, 0, 0);
        wait_done();
        chk("t2_beats", nbeats, 2);
        chk("t2_arr0", beat_arr[0], 1);
        chk("t2_arr1", beat_arr[1], 3);
        chk("t2_stray", err_stray, 1);

        // full tile with a 20-cycle stall
        start_tile(16, 4'b1111);
        feed(16, 4'b1111, 1, 999, 5, 20);
        wait_done();
        chk("t3_beats", nbeats, 64);
        chk("t3_stray_cleared", err_stray, 0);
        chk("t3_ovf", err_overflow, 0);

        // overflow on column 5 after its row count is reached
        out_ready = 1'b0;
        start_tile(3, 4'b0001);
        feed(3, 4'b0001, 0, 999, 0, 0);
        sa_valid_out[0][5] = 1'b1;
        sa_output[0][5] = 32'hDEADBEEF;
        @(posedge clk); #1;
        sa_valid_out = '0;
        sa_output = '0;
        out_ready = 1'b1;
        wait_done();
        chk("t4_ovf", err_overflow, 1);
        chk("t4_beats", nbeats, 3);

        // reset mid-tile after 7 rows captured, then a clean tile
        start_tile(16, 4'b0001);
        feed(16, 4'b0001, 0, 7, 0, 0);
        chk("t5_busy_before", busy, 1);
        rst = 1'b1;
        #2;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_tile(2, 4'b0101);
        feed(2, 4'b0101, 1, 999, 0, 0);
        wait_done();
        chk("t5_beats", nbeats, 4);
        chk("t5_arr1", beat_arr[1], 2);
        chk("t5_arr2", beat_arr[2], 0);

        // illegal starts are ignored
        start_tile(4, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        start_tile(0, 4'b0001);
        repeat (3) @(posedge clk);
        #1;
        chk("t6z_busy", busy, 0);
        chk("t6_beats", nbeats, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
